// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters; accept at N, response at N+2.
// One op in flight at a time; a stalled response holds both requesters off until rsp_ready[owner].
module alu_share_arbiter #(
  parameter int Width = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [Width-1:0] req0_a,
  input  logic [Width-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [Width-1:0] req1_a,
  input  logic [Width-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [Width-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [Width-1:0] alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic             owner;
  logic [Width-1:0] a_q, b_q;
  logic [3:0]       ctrl_q;
  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic             done;
  logic             ctrl_legal;

  // Contention resolves to prio; a lone requester always wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = prio;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign accept = (state == IDLE) & grant_vld;
  assign done   = (state == RESP) & rsp_ready[owner];

  assign req0_ready = ~reset & accept & ~grant_id;
  assign req1_ready = ~reset & accept & grant_id;

  always_comb begin
    rsp_valid = 2'b00;
    if (!reset && state == RESP) rsp_valid[owner] = 1'b1;
  end

  always_comb begin
    case (ctrl_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: ctrl_legal = 1'b1;
      default:                                              ctrl_legal = 1'b0;
    endcase
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (accept) begin
        owner  <= grant_id;
        a_q    <= grant_id ? req1_a    : req0_a;
        b_q    <= grant_id ? req1_b    : req0_b;
        ctrl_q <= grant_id ? req1_ctrl : req0_ctrl;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= ~ctrl_legal;
      end
      if (done) begin
        prio <= ~owner;
        // Counters stick at all-ones rather than wrapping.
        if (owner) begin
          if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
        end else begin
          if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: driver predicts grants and pushes expected responses,
// an independent monitor pops them when the DUT presents a response.
module tb_alu_share_arbiter;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_ctrl, req1_ctrl;
  logic [1:0]    rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero, rsp_err;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_zero;
  logic [CW-1:0] cnt0, cnt1;

  alu_share_arbiter #(.Width(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural MIPS ALU: illegal codes produce 0.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic bit legal_ctrl(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  typedef struct {
    bit           owner;
    logic [W-1:0] res;
    bit           zero;
    bit           err;
    int           acc;
  } exp_t;

  exp_t sb[$];
  bit   m_prio = 1'b0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] legal_codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit owner, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] c);
    exp_t e;
    e.owner = owner;
    e.res   = alu_fn(a, b, c);
    e.zero  = (e.res == '0);
    e.err   = !legal_ctrl(c);
    e.acc   = cyc;
    sb.push_back(e);
  endtask

  task automatic newop(input int i);
    bit v;
    logic [3:0] c;
    logic [W-1:0] a, b;
    v = ($urandom_range(0, 3) != 0);
    c = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_codes[$urandom_range(0, 5)];
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (i == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  // One cycle: predict and check the grant before the edge, then drive the next inputs.
  task automatic step(input bit rnd);
    logic [1:0] exp_rdy;
    int w;
    @(negedge clk);
    exp_rdy = 2'b00;
    w = -1;
    if (!reset && sb.size() == 0) begin
      if (req0_valid && req1_valid) w = int'(m_prio);
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
    if (w == 0) push_exp(1'b0, req0_a, req0_b, req0_ctrl);
    if (w == 1) push_exp(1'b1, req1_a, req1_b, req1_ctrl);
    @(posedge clk);
    #1;
    if (rnd) begin
      if (w == 0 || !req0_valid) newop(0);
      if (w == 1 || !req1_valid) newop(1);
      rsp_ready = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // Monitor: compares every presented response against the head of the scoreboard.
  logic [1:0] mon_ev;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        check("cnt0", 64'(cnt0), 64'(m_cnt0));
        check("cnt1", 64'(cnt1), 64'(m_cnt1));
        mon_ev = 2'b00;
        if (sb.size() > 0 && cyc >= sb[0].acc + 2) mon_ev[sb[0].owner] = 1'b1;
        check("rsp_valid", 64'(rsp_valid), 64'(mon_ev));
        if (mon_ev != 2'b00 && rsp_valid == mon_ev) begin
          check("rsp_result", 64'(rsp_result), 64'(sb[0].res));
          check("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
          check("rsp_err", 64'(rsp_err), 64'(sb[0].err));
          if (rsp_ready[sb[0].owner]) begin
            m_prio = ~sb[0].owner;
            if (sb[0].owner) m_cnt1 = (m_cnt1 == 15) ? 15 : m_cnt1 + 1;
            else             m_cnt0 = (m_cnt0 == 15) ? 15 : m_cnt0 + 1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp_ready  = 2'b00;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_rsp_regs", 64'({rsp_err, rsp_zero, rsp_result}), 64'(0));

    // Both valid from reset: SUB 9-9 vs SLT 3<4, grants alternate.
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_ctrl = 4'b0110;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_ctrl = 4'b0111;
    rsp_ready  = 2'b11;
    repeat (12) step(0);
    req0_valid = 0; req1_valid = 0;
    repeat (3) step(0);

    // Lone requester 0: ADD 7+5, back-to-back.
    req0_valid = 1; req0_a = 7; req0_b = 5; req0_ctrl = 4'b0010;
    repeat (6) step(0);
    req0_valid = 0;
    repeat (3) step(0);

    // Backpressure in RESP with requester 1 waiting.
    req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h0FF0_F00F; req0_ctrl = 4'b0000;
    rsp_ready  = 2'b00;
    step(0);
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'h10; req1_b = 32'h20; req1_ctrl = 4'b0001;
    repeat (7) step(0);
    rsp_ready = 2'b01;
    step(0);
    rsp_ready = 2'b11;
    repeat (4) step(0);
    req1_valid = 0;
    repeat (3) step(0);

    // Illegal control code from requester 1.
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h5; req1_ctrl = 4'b1111;
    step(0);
    req1_valid = 0;
    repeat (4) step(0);

    // Reset while a response is stalled; prio must return to 0.
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_ctrl = 4'b0010;
    repeat (3) step(0);
    rsp_ready = 2'b00;
    repeat (3) step(0);
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp_ready = 2'b11;
    repeat (4) step(0);
    req0_valid = 0; req1_valid = 0;
    repeat (3) step(0);

    // Saturation: 20 ops from requester 0 on a 4-bit counter.
    req0_valid = 1; req0_a = 32'hA; req0_b = 32'h3; req0_ctrl = 4'b0110;
    repeat (60) step(0);
    req0_valid = 0;
    repeat (3) step(0);
    check("cnt0_saturated", 64'(cnt0), 64'(4'hF));

    // Randomized traffic.
    newop(0);
    newop(1);
    repeat (400) step(1);
    req0_valid = 0; req1_valid = 0; rsp_ready = 2'b11;
    repeat (6) step(0);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one MIPS_ALU instance between two requesters, such as the main datapath and a branch/address unit, using a round-robin arbiter and a three-state sequencer. Each requester presents operands and a 4-bit ALU control code over a valid/ready handshake. It gets back a registered result, zero flag and illegal-op flag over a second valid/ready handshake. The block sits beside the ALU: it drives the ALU operand and control inputs and captures ALUResult and Zero.

Parameters:
Width, 32, operand and result width (matches the ALU Width)
CNT_W, 16, width of the per-requester completed-operation counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  Width  requester 0 operand A
req0_b  input  Width  requester 0 operand B
req0_ctrl  input  4  requester 0 ALU control code
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0, for requester 1
rsp_valid  output  2  bit i: response pending for requester i (one-hot or zero)
rsp_ready  input  2  bit i: requester i accepts the response
rsp_result  output  Width  captured ALU result, shared by both requesters
rsp_zero  output  1  captured Zero flag
rsp_err  output  1  control code was not a legal ALU code
alu_a  output  Width  to ALU A
alu_b  output  Width  to ALU B
alu_ctrl  output  4  to ALU ALUControl
alu_result  input  Width  from ALU ALUResult
alu_zero  input  1  from ALU Zero
cnt0  output  CNT_W  completed ops for requester 0, saturating
cnt1  output  CNT_W  completed ops for requester 1, saturating

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, prio=0, owner=0.
  - Operand/ctrl registers, rsp_result, rsp_zero, rsp_err, cnt0 and cnt1 all cleared to 0.
  - rsp_valid=00; both req_ready=0 during the reset cycle.
- alu_a, alu_b and alu_ctrl are driven directly from the operand/ctrl registers in all states. They hold their last value outside EXEC.
- Legal ALU codes: 0000 (AND), 0001 (OR), 0010 (ADD), 0110 (SUB), 0111 (SLT), 1100 (NOR). Any other code is illegal.
- IDLE:
  - req_ready_i = (state==IDLE) & req_i_valid & (i is the winner). This is combinational.
  - Winner: the only valid requester; if both are valid, the requester equal to prio.
  - On accept: latch a, b, ctrl and owner=i, then go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Capture rsp_result=alu_result and rsp_zero=alu_zero.
  - rsp_err = 1 if ctrl is illegal; rsp_result is still the captured alu_result, which the ALU forces to 0.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit is 0.
  - rsp_result, rsp_zero and rsp_err are stable while waiting.
  - On rsp_ready[owner]=1: increment cnt_owner (saturate at all-ones), set prio=~owner, go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Accept at cycle N, rsp_valid high at N+2.
  - With rsp_ready held high, the next accept is at N+3, so peak throughput is one op per 3 cycles.
- No new request is accepted in EXEC or RESP; requesters must hold valid and operands until ready.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... starting from prio at reset.
- A lone requester keeps winning back-to-back; prio still flips after each completion.
- Reset in EXEC or RESP: the in-flight op is discarded, no response is issued, the counters are not incremented, and the block returns to IDLE.
- Counters never wrap.

Test Plan:
1. req0 only: a=7, b=5, ctrl=0010 at cycle N -> req0_ready=1 at N; rsp_valid=01 at N+2 with rsp_result=12, rsp_zero=0, rsp_err=0; cnt0=1 after the handshake.
2. Both valid from reset: req0 ctrl=0110 a=b=9; req1 ctrl=0111 a=3 b=4 -> grant req0 first (result 0, zero=1), then req1 (result 1, zero=0). Continuing both valid gives grants alternating 0,1,0,1.
3. Backpressure: hold rsp_ready=00 for 5 cycles in RESP -> rsp_valid stays 01 and result stays stable; req1_ready stays 0 throughout; completes on the first rsp_ready[0]=1 cycle.
4. Illegal ctrl=1111 from req1 with a=0xFFFF_FFFF -> rsp_result=0, rsp_zero=1, rsp_err=1; cnt1 increments.
5. Assert reset during RESP -> next cycle rsp_valid=00, state=IDLE, counters=0, prio=0; no response delivered.
6. Force cnt0 to all-ones via 2^CNT_W ops (CNT_W=4 build) -> cnt0 stays 4'hF after the 16th and 17th ops.
